// File: rtl/waveform_capture_pkg.sv
// Shared types, sizes and the trigger comparator for the waveform capture path.
package waveform_pkg;

  localparam int DATA_W       = 12;
  localparam int ADDR_W       = 10;
  localparam int X_W          = 11;
  localparam int Y_W          = 10;
  localparam int CNT_W        = 10;
  localparam int TMO_W        = 13;
  localparam int X_START      = 20;
  localparam int X_END        = 770;
  localparam int REC_LEN      = X_END - X_START + 1;
  localparam int PRETRIG      = 64;
  localparam int POSTTRIG     = REC_LEN - PRETRIG - 1;
  localparam int AUTO_TIMEOUT = 4096;
  localparam int REFRESH_Y    = 770;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFILL  = 3'd1,
    ARMED    = 3'd2,
    POSTFILL = 3'd3,
    HOLD     = 3'd4
  } capture_state_t;

  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    NORMAL = 2'd1,
    SINGLE = 2'd2
  } trig_mode_t;

  // Edge-crossing test between the previous and current sample.
  function automatic logic trig_hit(input logic [DATA_W-1:0] prev,
                                    input logic [DATA_W-1:0] cur,
                                    input logic [DATA_W-1:0] level,
                                    input logic              falling);
    logic hit;
    if (falling) begin
      hit = (prev > level) && (cur <= level);
    end else begin
      hit = (prev < level) && (cur >= level);
    end
    return hit;
  endfunction

endpackage

// File: rtl/waveform_capture_if.sv
// Sample input, trigger controls, raster position and readout of the capture block.
interface waveform_capture_if;
  import waveform_pkg::*;

  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic [1:0]        trig_mode;
  logic              arm;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [DATA_W-1:0] data;
  logic              triggered;
  logic              capturing;

  modport master (
    output sample_valid, sample_data, trig_level, trig_slope, trig_mode, arm, x, y,
    input  data, triggered, capturing
  );

  modport slave (
    input  sample_valid, sample_data, trig_level, trig_slope, trig_mode, arm, x, y,
    output data, triggered, capturing
  );
endinterface

// File: rtl/waveform_capture_ram.sv
// Two 1024-entry sample banks: writes go to the back bank, reads come from the front bank.
module capture_ram
  import waveform_pkg::*;
(
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              front_sel_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] bank0_q [2**ADDR_W];
  logic [DATA_W-1:0] bank1_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write the bank that is not currently on display.
  always_ff @(posedge clk) begin
    if (we_i) begin
      if (front_sel_i) begin
        bank0_q[waddr_i] <= wdata_i;
      end else begin
        bank1_q[waddr_i] <= wdata_i;
      end
    end
  end

  // Registered read of the front bank; a disabled read yields zero for blank columns.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 12'd0;
    end else if (re_i) begin
      rdata_q <= front_sel_i ? bank1_q[raddr_i] : bank0_q[raddr_i];
    end else begin
      rdata_q <= 12'd0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/waveform_capture.sv
// Triggered record capture into a back bank, tear-free swap at refresh, per-column readout.
module waveform_capture
  import waveform_pkg::*;
(
  input logic               clk,
  input logic               reset,
  waveform_capture_if.slave bus
);

  capture_state_t    state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              forced_q, forced_d;
  logic              front_q, front_d;
  logic [ADDR_W-1:0] front_start_q, front_start_d;
  logic              triggered_q, triggered_d;
  logic              capturing_q, capturing_d;

  logic              refresh_s, hit_s, we_s, single_s, auto_s, tmo_max_s;
  logic [X_W:0]      xn_s, off_s;
  logic              re_s;
  logic [ADDR_W-1:0] raddr_s;

  // Strobes and readout addressing; x+1 lookahead hides the RAM read latency.
  always_comb begin
    refresh_s = (bus.x == 11'd0) && (bus.y == 10'(REFRESH_Y));
    single_s  = (bus.trig_mode == SINGLE);
    auto_s    = (bus.trig_mode == AUTO);
    tmo_max_s = (tmo_q == 13'(AUTO_TIMEOUT - 1));
    hit_s     = prev_valid_q &&
                trig_hit(prev_q, bus.sample_data, bus.trig_level, bus.trig_slope);
    we_s      = bus.sample_valid &&
                ((state_q == PREFILL) || (state_q == ARMED) || (state_q == POSTFILL));
    xn_s      = {1'b0, bus.x} + 12'd1;
    off_s     = xn_s - 12'(X_START);
    raddr_s   = front_start_q + off_s[ADDR_W-1:0];
    re_s      = (xn_s >= 12'(X_START)) && (xn_s <= 12'(X_END));
  end

  // Capture sequencing: next state, counters, trigger latch and bank swap.
  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    trig_addr_d   = trig_addr_q;
    forced_d      = forced_q;
    front_d       = front_q;
    front_start_d = front_start_q;
    triggered_d   = triggered_q;

    if (we_s) begin
      wptr_d       = wptr_q + 10'd1;
      prev_d       = bus.sample_data;
      prev_valid_d = 1'b1;
    end else begin
      wptr_d = wptr_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.arm || !single_s) begin
          state_d      = PREFILL;
          cnt_d        = 10'd0;
          prev_valid_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      PREFILL: begin
        if (bus.sample_valid) begin
          if (cnt_q == 10'(PRETRIG - 1)) begin
            state_d = ARMED;
            cnt_d   = 10'd0;
            tmo_d   = 13'd0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end else begin
          state_d = PREFILL;
        end
      end
      ARMED: begin
        if (bus.sample_valid) begin
          if (hit_s) begin
            trig_addr_d = wptr_q;
            forced_d    = 1'b0;
            state_d     = POSTFILL;
            cnt_d       = 10'd0;
          end else if (auto_s && tmo_max_s) begin
            trig_addr_d = wptr_q;
            forced_d    = 1'b1;
            state_d     = POSTFILL;
            cnt_d       = 10'd0;
          end else if (!tmo_max_s) begin
            tmo_d = tmo_q + 13'd1;
          end else begin
            tmo_d = tmo_q;
          end
        end else begin
          state_d = ARMED;
        end
      end
      POSTFILL: begin
        if (bus.sample_valid) begin
          if (cnt_q == 10'(POSTTRIG - 1)) begin
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end else begin
          state_d = POSTFILL;
        end
      end
      HOLD: begin
        if (refresh_s) begin
          front_d       = ~front_q;
          front_start_d = trig_addr_q - 10'(PRETRIG);
          triggered_d   = ~forced_q;
          if (single_s) begin
            state_d = IDLE;
          end else begin
            state_d      = PREFILL;
            cnt_d        = 10'd0;
            prev_valid_d = 1'b0;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    capturing_d = (state_d == PREFILL) || (state_d == ARMED) || (state_d == POSTFILL);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wptr_q        <= 10'd0;
      cnt_q         <= 10'd0;
      tmo_q         <= 13'd0;
      prev_q        <= 12'd0;
      prev_valid_q  <= 1'b0;
      trig_addr_q   <= 10'd0;
      forced_q      <= 1'b0;
      front_q       <= 1'b0;
      front_start_q <= 10'd0;
      triggered_q   <= 1'b0;
      capturing_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      trig_addr_q   <= trig_addr_d;
      forced_q      <= forced_d;
      front_q       <= front_d;
      front_start_q <= front_start_d;
      triggered_q   <= triggered_d;
      capturing_q   <= capturing_d;
    end
  end

  capture_ram u_ram (
    .clk         (clk),
    .rst_ni      (reset),
    .front_sel_i (front_q),
    .we_i        (we_s),
    .waddr_i     (wptr_q),
    .wdata_i     (bus.sample_data),
    .re_i        (re_s),
    .raddr_i     (raddr_s),
    .rdata_o     (bus.data)
  );

  assign bus.triggered = triggered_q;
  assign bus.capturing = capturing_q;

endmodule

// File: tb/tb_waveform_capture.sv
// Randomized bench for waveform_capture with an index-based record model.
module tb_waveform_capture;
  import waveform_pkg::*;

  logic clk;
  logic reset;
  waveform_capture_if bus_if();

  waveform_capture dut (.clk(clk), .reset(reset), .bus(bus_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Trigger settings as the model sees them
  logic [1:0]  m_mode;
  logic        m_slope;
  logic [11:0] m_level;

  // Samples accepted by the current capture, oldest first
  logic [11:0] hist[$];
  int          trig_i;
  bit          forced_m;
  bit          hold_m;
  bit          feeding;
  bit          last_refresh;
  int          feed_post;
  int          gen_kind, gen_cnt, gen_n;
  logic [11:0] gen_a, gen_b;

  // What the display should currently show
  logic [11:0] front_exp [REC_LEN];
  bit          front_known;
  bit          trig_exp;

  task automatic set_trig(input logic [1:0] mode, input logic slope, input logic [11:0] level);
    m_mode = mode; m_slope = slope; m_level = level;
    bus_if.trig_mode = mode; bus_if.trig_slope = slope; bus_if.trig_level = level;
  endtask

  task automatic model_start(input int kind, input logic [11:0] a, input logic [11:0] b, input int n);
    hist.delete();
    trig_i = -1; forced_m = 1'b0; hold_m = 1'b0;
    gen_kind = kind; gen_a = a; gen_b = b; gen_n = n; gen_cnt = 0;
  endtask

  function automatic logic [11:0] gen_next();
    logic [11:0] s;
    case (gen_kind)
      0:       s = gen_a + 12'(gen_cnt);
      1:       s = gen_a;
      2:       s = (gen_cnt < gen_n) ? gen_a : gen_b;
      default: s = 12'($urandom_range(0, 4095));
    endcase
    gen_cnt++;
    return s;
  endfunction

  function automatic bit rec_done(input int post);
    return (trig_i >= 0) && (hist.size() >= trig_i + 1 + post);
  endfunction

  function automatic void model_push(input logic [11:0] s);
    int i;
    logic [11:0] p;
    bit hit;
    hist.push_back(s);
    i = hist.size() - 1;
    if (trig_i < 0 && i >= PRETRIG) begin
      p = hist[i-1];
      hit = m_slope ? (p > m_level && s <= m_level) : (p < m_level && s >= m_level);
      if (hit) begin
        trig_i = i;
      end else if (m_mode == 2'd0 && i == PRETRIG + AUTO_TIMEOUT - 1) begin
        trig_i = i; forced_m = 1'b1;
      end
    end
    if (rec_done(POSTTRIG)) hold_m = 1'b1;
  endfunction

  function automatic logic [11:0] exp_col(input int c);
    if (front_known && c >= X_START && c <= X_END) return front_exp[c-X_START];
    else return 12'd0;
  endfunction

  task automatic drive_sample();
    logic [11:0] s;
    if (feeding && !rec_done(feed_post) && $urandom_range(0, 3) != 0) begin
      s = gen_next();
      bus_if.sample_valid = 1'b1;
      bus_if.sample_data  = s;
      model_push(s);
      if (last_refresh && rec_done(POSTTRIG)) begin
        bus_if.x = 11'd0; bus_if.y = 10'(REFRESH_Y);
      end
    end else begin
      bus_if.sample_valid = 1'b0;
      bus_if.sample_data  = 12'($urandom_range(0, 4095));
    end
  endtask

  task automatic tick();
    drive_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run_capture(input int post);
    int n = 0;
    feed_post = post;
    feeding = 1'b1;
    while (!rec_done(post) && n < 12000) begin
      tick();
      n++;
    end
    feeding = 1'b0;
    bus_if.sample_valid = 1'b0;
    bus_if.x = 11'd5; bus_if.y = 10'd0;
    checks++;
    if (!rec_done(post)) begin
      errors++;
      $display("FAIL capture_timeout: got %0d samples, trigger index %0d", hist.size(), trig_i);
    end
  endtask

  task automatic do_refresh();
    bus_if.sample_valid = 1'b0;
    bus_if.x = 11'd0; bus_if.y = 10'(REFRESH_Y);
    @(posedge clk);
    #1;
    bus_if.x = 11'd5; bus_if.y = 10'd0;
    if (hold_m) begin
      for (int k = 0; k < REC_LEN; k++) front_exp[k] = hist[trig_i - PRETRIG + k];
      front_known = 1'b1;
      trig_exp = !forced_m;
      hold_m = 1'b0;
    end
  endtask

  task automatic check_flag(input string name, input logic got, input logic want);
    @(negedge clk);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", name, got, want);
    end
  endtask

  task automatic check_col_val(input int c, input logic [11:0] want, input string name);
    bus_if.x = 11'(c - 1); bus_if.y = 10'd100;
    tick();
    bus_if.x = 11'(c);
    @(negedge clk);
    checks++;
    if (bus_if.data !== want) begin
      errors++;
      $display("FAIL %s: x=%0d got %0d want %0d", name, c, bus_if.data, want);
    end
    bus_if.x = 11'd5; bus_if.y = 10'd0;
  endtask

  task automatic sweep_check(input int row, input int lo, input int hi, input string name);
    int bad = 0;
    int first = -1;
    logic [11:0] g, e, gf, ef;
    bus_if.y = 10'(row); bus_if.x = 11'(lo - 1);
    tick();
    for (int c = lo; c <= hi; c++) begin
      bus_if.x = 11'(c);
      @(negedge clk);
      g = bus_if.data; e = exp_col(c);
      if (g !== e) begin
        if (bad == 0) begin first = c; gf = g; ef = e; end
        bad++;
      end
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d columns wrong, first x=%0d got %0d want %0d", name, bad, first, gf, ef);
    end
    bus_if.x = 11'd5; bus_if.y = 10'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_if.sample_valid = 1'b0; bus_if.sample_data = 12'd0; bus_if.arm = 1'b0;
    bus_if.x = 11'd5; bus_if.y = 10'd0;
    set_trig(2'd1, 1'b0, 12'd2000);
    feeding = 1'b0; last_refresh = 1'b0; front_known = 1'b0; hold_m = 1'b0; feed_post = POSTTRIG;
    repeat (3) @(posedge clk);
    check_flag("reset_data_zero", bus_if.data == 12'd0, 1'b1);
    check_flag("reset_triggered", bus_if.triggered, 1'b0);
    check_flag("reset_capturing", bus_if.capturing, 1'b0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    check_flag("normal_leaves_idle", bus_if.capturing, 1'b1);
  endtask

  task automatic test_ramp();
    model_start(0, 12'd0, 12'd0, 0);
    run_capture(POSTTRIG);
    check_flag("ramp_hold", bus_if.capturing, 1'b0);
    check_flag("ramp_no_swap_yet", bus_if.triggered, 1'b0);
    do_refresh();
    check_flag("ramp_triggered", bus_if.triggered, 1'b1);
    check_col_val(20, 12'd1936, "ramp_x20");
    check_col_val(84, 12'd2000, "ramp_x84");
    check_col_val(770, 12'd2686, "ramp_x770");
    check_col_val(19, 12'd0, "ramp_x19_blank");
    check_col_val(771, 12'd0, "ramp_x771_blank");
    sweep_check(100, 19, 771, "ramp_sweep");
  endtask

  task automatic test_auto();
    set_trig(2'd0, 1'b0, 12'd2000);
    model_start(1, 12'd100, 12'd0, 0);
    run_capture(POSTTRIG);
    check_flag("auto_hold", bus_if.capturing, 1'b0);
    do_refresh();
    check_flag("auto_forced_untriggered", bus_if.triggered, 1'b0);
    check_col_val(20, 12'd100, "auto_x20");
    check_col_val(770, 12'd100, "auto_x770");
    check_col_val(19, 12'd0, "auto_x19_blank");
    check_col_val(771, 12'd0, "auto_x771_blank");
    sweep_check(200, 19, 771, "auto_sweep");
  endtask

  task automatic test_falling_same_cycle_refresh();
    set_trig(2'd1, 1'b1, 12'd1000);
    model_start(2, 12'd3000, 12'd500, 100);
    last_refresh = 1'b1;
    run_capture(POSTTRIG);
    last_refresh = 1'b0;
    check_flag("falling_hold", bus_if.capturing, 1'b0);
    check_flag("coincident_refresh_no_swap", bus_if.triggered, 1'b0);
    check_col_val(84, 12'd100, "coincident_old_record");
    do_refresh();
    check_flag("falling_triggered", bus_if.triggered, 1'b1);
    check_col_val(84, 12'd500, "falling_x84");
    check_col_val(83, 12'd3000, "falling_x83");
    sweep_check(100, 19, 771, "falling_sweep");
  endtask

  task automatic test_tear();
    set_trig(2'd1, 1'($urandom_range(0, 1)), 12'($urandom_range(1000, 3000)));
    model_start(3, 12'd0, 12'd0, 0);
    feed_post = POSTTRIG;
    feeding = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (!rec_done(POSTTRIG)) sweep_check(300, 1, 799, "tear_row300_during_capture");
    end
    feeding = 1'b0;
    run_capture(POSTTRIG);
    check_flag("tear_hold", bus_if.capturing, 1'b0);
    sweep_check(300, 1, 799, "tear_row300_before_refresh");
    do_refresh();
    check_flag("tear_triggered", bus_if.triggered, trig_exp);
    sweep_check(300, 1, 799, "tear_row300_after_refresh");
  endtask

  task automatic test_single();
    set_trig(2'd2, 1'b0, 12'd1500);
    model_start(0, 12'd1000, 12'd0, 0);
    run_capture(POSTTRIG);
    do_refresh();
    check_flag("single_idle_after_swap", bus_if.capturing, 1'b0);
    check_flag("single_triggered", bus_if.triggered, 1'b1);
    for (int k = 0; k < 200; k++) begin
      bus_if.sample_valid = 1'b1;
      bus_if.sample_data  = 12'(1400 + k);
      @(posedge clk); #1;
    end
    bus_if.sample_valid = 1'b0;
    check_flag("single_ignores_samples", bus_if.capturing, 1'b0);
    do_refresh();
    sweep_check(100, 19, 771, "single_record_kept");
    bus_if.arm = 1'b1;
    @(posedge clk); #1;
    bus_if.arm = 1'b0;
    check_flag("single_arm_restarts", bus_if.capturing, 1'b1);
    set_trig(2'd2, 1'b0, 12'd3100);
    model_start(0, 12'd3000, 12'd0, 0);
    run_capture(POSTTRIG);
    check_col_val(84, 12'd1500, "single_old_until_refresh");
    do_refresh();
    check_col_val(84, 12'd3100, "single_new_x84");
    check_flag("single_idle_again", bus_if.capturing, 1'b0);
  endtask

  task automatic test_reset_mid();
    set_trig(2'd1, 1'b0, 12'd2000);
    @(posedge clk); #1;
    model_start(0, 12'd0, 12'd0, 0);
    run_capture(300);
    check_flag("postfill_capturing", bus_if.capturing, 1'b1);
    bus_if.x = 11'd82; bus_if.y = 10'd100;
    @(posedge clk); #1;
    bus_if.x = 11'd83;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus_if.data !== 12'd0 || bus_if.triggered !== 1'b0 || bus_if.capturing !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: data=%0d trig=%0b cap=%0b want 0/0/0",
               bus_if.data, bus_if.triggered, bus_if.capturing);
    end
    bus_if.x = 11'd5; bus_if.y = 10'd0;
    front_known = 1'b0; hold_m = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    check_flag("reset_mid_restarts", bus_if.capturing, 1'b1);
    do_refresh();
    check_flag("refresh_outside_hold", bus_if.triggered, 1'b0);
    set_trig(2'd3, 1'b0, 12'd1000);
    model_start(0, 12'd500, 12'd0, 0);
    run_capture(POSTTRIG);
    check_flag("reset_mid_no_swap_yet", bus_if.triggered, 1'b0);
    do_refresh();
    check_flag("reset_mid_new_triggered", bus_if.triggered, 1'b1);
    sweep_check(100, 19, 771, "reset_mid_new_record");
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_auto();
    test_falling_same_cycle_refresh();
    test_tear();
    test_single();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/waveform_capture.md
Name: waveform_capture

Overview:
- Upstream stage of the waveform display path.
- Captures a triggered record of 12-bit ADC samples into a double-buffered sample memory.
- Serves the frozen record back, one sample per pixel column, on `data` to the waveform renderer, indexed by the same `x`/`y` raster counters.
- Bank swap happens only at the display refresh point (x==0, y==770), so a frame never tears.

Parameters:
- DATA_W, 12, sample width.
- ADDR_W, 10, bank address width (1024 entries per bank).
- X_START, 20, first plotted column.
- X_END, 770, last plotted column; record length REC_LEN = X_END-X_START+1 = 751.
- PRETRIG, 64, samples kept before the trigger point.
- AUTO_TIMEOUT, 4096, valid samples in ARMED before auto mode forces a trigger.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sample_valid  in  1  qualifies sample_data for one cycle
- sample_data  in  12  ADC sample
- trig_level  in  12  trigger threshold (unsigned)
- trig_slope  in  1  0 = rising, 1 = falling
- trig_mode  in  2  0 = auto, 1 = normal, 2 = single, 3 = treated as normal
- arm  in  1  single-cycle pulse; re-arms single mode
- x  in  11  current raster column
- y  in  10  current raster row
- data  out  12  sample for the current column
- triggered  out  1  high while the front bank holds a trigger-qualified record (low if auto-forced)
- capturing  out  1  high in PREFILL/ARMED/POSTFILL

Behaviour:
- Reset (reset==0, async): state=IDLE, data=0, triggered=0, capturing=0, front bank=0, write pointer=0, prev_valid=0, counters=0. Memory contents are not reset.
- Refresh strobe: refresh = (x==0 && y==770), combinational.
- States and transitions:
  - IDLE: wait; exit to PREFILL on arm, or immediately when trig_mode != single.
  - PREFILL: write each valid sample to the back bank at wptr; wptr increments mod 1024. After PRETRIG writes, go to ARMED.
  - ARMED: keep writing (circular).
    - Trigger condition, evaluated only on a valid sample with prev_valid=1:
      - rising: prev < trig_level && sample >= trig_level;
      - falling: prev > trig_level && sample <= trig_level.
    - On trigger: trig_addr = address of the triggering sample; go to POSTFILL.
    - Auto mode only: if AUTO_TIMEOUT valid samples pass without a trigger, force trig_addr = current wptr, set forced=1, go to POSTFILL.
  - POSTFILL: write REC_LEN-PRETRIG-1 = 686 further samples, then go to HOLD.
  - HOLD: ignore samples. On refresh:
    - swap banks;
    - latch front_start = trig_addr - PRETRIG (mod 1024);
    - triggered <= !forced;
    - next state = IDLE if single, else PREFILL.
- prev register: updated on every valid sample in PREFILL/ARMED/POSTFILL. prev_valid is cleared on entering PREFILL and set on the first valid sample.
- A trigger condition on the same cycle as the final PREFILL write is ignored; it needs the ARMED state.
- A refresh outside HOLD has no effect. A refresh and a capture completion in the same cycle: the swap waits for the next refresh.
- arm outside IDLE is ignored. A trig_mode change mid-capture takes effect at the next IDLE/PREFILL decision; the auto timeout counter uses the live mode.
- Readout:
  - Read address = front_start + (x+1-X_START) mod 1024, from the front bank. The +1 lookahead compensates the 1-cycle registered RAM read, so data aligns with x.
  - data is forced to 0 when the aligned x is outside [X_START, X_END].
  - Read and write target different banks, so there is never a read-write conflict.
- Widths: all address arithmetic is ADDR_W bits with natural wrap. Comparisons are unsigned on DATA_W.

Decomposition:
- Package waveform_pkg holds:
  - capture_state_t enum: IDLE, PREFILL, ARMED, POSTFILL, HOLD;
  - trig_mode_t enum: AUTO, NORMAL, SINGLE;
  - localparams REFRESH_Y=770 and the default X_START/X_END.
- Sub-module capture_ram: two banks of 1024x12 simple dual-port synchronous RAM. Write port selects the back bank, read port selects the front bank, one bank-select input.

Test Plan:
- Ramp 0..4095 (+1 per valid), normal mode, rising, level 2000 -> after refresh, data at x=20 is 1936, at x=84 is 2000, at x=770 is 2686; triggered=1.
- Constant 100 in auto mode, level 2000 -> after 64+4096+686 samples, HOLD; at refresh triggered=0 and data=100 on columns 20..770, 0 at x=19 and x=771.
- Falling slope: step 3000 -> 500, level 1000 -> trigger sample (500) appears at x=84, sample 3000 at x=83.
- Single mode: after one record and swap, state=IDLE and capturing=0; further triggers change nothing. An arm pulse restarts PREFILL, and the next record is shown only after the following refresh.
- Reset deasserted mid-POSTFILL, then re-released -> data=0, triggered=0, state=IDLE/PREFILL per mode; the old front bank is not shown until a new full record swaps in.
- Tear check: feed a new record while x sweeps row 300 -> data for row 300 unchanged until the x=0, y=770 refresh.
